// File: rtl/genius_button_encoder.sv
// Debounced five-button encoder for a Simon-style game controller.
// Emits a single registered strobe with a 3-bit code per accepted press.
module genius_button_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_POWER,
    input  logic       BTN_GREEN,
    input  logic       BTN_RED,
    input  logic       BTN_BLUE,
    input  logic       BTN_YELLOW,
    input  logic       ACCEPT_COLOR,
    output logic       R,
    output logic [2:0] B,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        EMIT,
        HELD,
        RELEASE_DB
    } state_t;

    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    state_t           state_reg;
    logic [4:0]       btn_raw;
    logic [4:0]       sync1_reg;
    logic [4:0]       s_reg;
    logic [4:0]       cand_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_inc;
    logic             s_permitted;
    logic             cand_held;

    // Bit 0 is POWER; only colour bits are subject to ACCEPT_COLOR.
    assign btn_raw     = {BTN_YELLOW, BTN_BLUE, BTN_RED, BTN_GREEN, BTN_POWER};
    assign cnt_inc     = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
    assign s_permitted = $onehot(s_reg) && (s_reg[0] || ACCEPT_COLOR);
    assign cand_held   = (s_reg == cand_reg) && (cand_reg[0] || ACCEPT_COLOR);
    assign BUSY        = (state_reg != IDLE);

    function automatic logic [2:0] code_of(input logic [4:0] v);
        logic [2:0] c;
        case (v)
            5'b00001: c = 3'd1;
            5'b00010: c = 3'd2;
            5'b00100: c = 3'd3;
            5'b01000: c = 3'd4;
            5'b10000: c = 3'd6;
            default:  c = 3'd0;
        endcase
        return c;
    endfunction

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync1_reg <= '0;
            s_reg     <= '0;
        end else begin
            sync1_reg <= btn_raw;
            s_reg     <= sync1_reg;
        end
    end

    // Reset lands in RELEASE_DB so a button held through reset must be
    // seen released for a full debounce window before any press counts.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg <= RELEASE_DB;
            cnt_reg   <= '0;
            cand_reg  <= '0;
            R         <= 1'b0;
            B         <= 3'd0;
        end else begin
            R <= 1'b0;
            B <= 3'd0;
            case (state_reg)
                IDLE: begin
                    if (s_permitted) begin
                        cand_reg  <= s_reg;
                        cnt_reg   <= '0;
                        state_reg <= PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (cand_held) begin
                        cnt_reg <= cnt_inc;
                        if (cnt_inc >= DB_LIMIT) begin
                            state_reg <= EMIT;
                            R         <= 1'b1;
                            B         <= code_of(cand_reg);
                        end
                    end else begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end
                end
                EMIT: begin
                    state_reg <= HELD;
                end
                HELD: begin
                    if (s_reg == 5'd0) begin
                        cnt_reg   <= '0;
                        state_reg <= RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (s_reg != 5'd0) begin
                        state_reg <= HELD;
                    end else begin
                        cnt_reg <= cnt_inc;
                        if (cnt_inc >= DB_LIMIT) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= RELEASE_DB;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_genius_button_encoder.sv
// Testbench for genius_button_encoder: directed scenarios plus random holds,
// every cycle compared against a run-length reference model.
module tb_genius_button_encoder;

    localparam int D = 4;
    localparam logic [4:0] P_POWER  = 5'b00001;
    localparam logic [4:0] P_GREEN  = 5'b00010;
    localparam logic [4:0] P_RED    = 5'b00100;
    localparam logic [4:0] P_BLUE   = 5'b01000;
    localparam logic [4:0] P_YELLOW = 5'b10000;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [4:0] btn;
    logic       ACCEPT_COLOR;
    logic       R;
    logic [2:0] B;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    genius_button_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .BTN_POWER    (btn[0]),
        .BTN_GREEN    (btn[1]),
        .BTN_RED      (btn[2]),
        .BTN_BLUE     (btn[3]),
        .BTN_YELLOW   (btn[4]),
        .ACCEPT_COLOR (ACCEPT_COLOR),
        .R            (R),
        .B            (B),
        .BUSY         (BUSY)
    );

    always #5 CLK = ~CLK;

    // Reference model: synchronizer delay line plus run lengths of
    // qualifying presses (m_qrun) and of all-zero samples while locked (m_zrun).
    logic [4:0] m_s1, m_s2, m_cand;
    int         m_qrun, m_zrun;
    bit         m_locked, m_skip;
    logic       exp_r;
    logic [2:0] exp_b;
    logic       exp_busy;

    function automatic logic [2:0] code_of(input logic [4:0] v);
        case (v)
            P_POWER:  return 3'd1;
            P_GREEN:  return 3'd2;
            P_RED:    return 3'd3;
            P_BLUE:   return 3'd4;
            P_YELLOW: return 3'd6;
            default:  return 3'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_cand = '0;
        m_qrun = 0; m_zrun = 1; m_locked = 1; m_skip = 0;
        exp_r = 0; exp_b = 3'd0; exp_busy = 1;
    endtask

    task automatic model_edge(input logic [4:0] raw, input logic acc);
        logic [4:0] s;
        bit qual;
        s = m_s2; m_s2 = m_s1; m_s1 = raw;
        exp_r = 0; exp_b = 3'd0;
        qual = (s != 5'd0) && ((s & (s - 5'd1)) == 5'd0) && (s[0] || acc);
        if (m_skip) begin
            m_skip = 0; m_locked = 1; m_zrun = 0;
        end else if (m_locked) begin
            if (s == 5'd0) m_zrun++; else m_zrun = 0;
            if (m_zrun >= D + 1) m_locked = 0;
        end else if (m_qrun > 0) begin
            if (qual && s == m_cand) begin
                m_qrun++;
                if (m_qrun == D + 1) begin
                    exp_r = 1; exp_b = code_of(m_cand); m_skip = 1; m_qrun = 0;
                end
            end else begin
                m_qrun = 0;
            end
        end else if (qual) begin
            m_cand = s; m_qrun = 1;
        end
        exp_busy = m_locked || m_skip || (m_qrun > 0);
    endtask

    task automatic tick(input logic [4:0] raw, input logic acc);
        btn = raw; ACCEPT_COLOR = acc;
        @(posedge CLK);
        model_edge(raw, acc);
        #1;
    endtask

    task automatic do_reset(input logic [4:0] raw);
        btn = raw; RESET = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b1;
    endtask

    task automatic test_reset();
        btn = '0; ACCEPT_COLOR = 1'b0; RESET = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({R, B, BUSY} !== 5'b0_000_1) begin
            errors++;
            $display("FAIL reset_hold: R/B/BUSY got %b/%0d/%b expected 0/0/1", R, B, BUSY);
        end
        RESET = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick('0, 1'b0);
            checks++;
            if ({R, B, BUSY} !== {exp_r, exp_b, exp_busy}) begin
                errors++;
                $display("FAIL reset_release cyc %0d: got %b/%0d/%b expected %b/%0d/%b",
                         i, R, B, BUSY, exp_r, exp_b, exp_busy);
            end
            checks++;
            if (BUSY !== (i < 4)) begin
                errors++;
                $display("FAIL reset_busy cyc %0d: BUSY got %b expected %b", i, BUSY, (i < 4));
            end
        end
    endtask

    task automatic test_green();
        int pulses = 0, lat = 0;
        logic [2:0] last_b = 3'd0;
        for (int i = 1; i <= 32; i++) begin
            tick((i <= 20) ? P_GREEN : 5'd0, 1'b1);
            checks++;
            if ({R, B, BUSY} !== {exp_r, exp_b, exp_busy}) begin
                errors++;
                $display("FAIL green cyc %0d: got %b/%0d/%b expected %b/%0d/%b",
                         i, R, B, BUSY, exp_r, exp_b, exp_busy);
            end
            if (R) begin pulses++; last_b = B; if (lat == 0) lat = i; end
        end
        checks++;
        if (pulses != 1 || last_b !== 3'd2 || lat != 2 + D + 1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL green_summary: pulses=%0d B=%0d latency=%0d BUSY=%b expected 1/2/%0d/0",
                     pulses, last_b, lat, BUSY, 2 + D + 1);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            tick((i <= 2) ? P_RED : 5'd0, 1'b1);
            checks++;
            if ({R, B, BUSY} !== {exp_r, exp_b, exp_busy}) begin
                errors++;
                $display("FAIL glitch cyc %0d: got %b/%0d/%b expected %b/%0d/%b",
                         i, R, B, BUSY, exp_r, exp_b, exp_busy);
            end
            if (R) pulses++;
        end
        checks++;
        if (pulses != 0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL glitch_summary: pulses=%0d BUSY=%b expected 0/0", pulses, BUSY);
        end
    endtask

    task automatic test_two_buttons();
        int pulses = 0;
        logic [2:0] last_b = 3'd0;
        for (int i = 1; i <= 37; i++) begin
            tick((i <= 10) ? (P_BLUE | P_YELLOW) : (i <= 25) ? P_BLUE : 5'd0, 1'b1);
            checks++;
            if ({R, B, BUSY} !== {exp_r, exp_b, exp_busy}) begin
                errors++;
                $display("FAIL two_buttons cyc %0d: got %b/%0d/%b expected %b/%0d/%b",
                         i, R, B, BUSY, exp_r, exp_b, exp_busy);
            end
            if (R) begin pulses++; last_b = B; end
        end
        checks++;
        if (pulses != 1 || last_b !== 3'd4) begin
            errors++;
            $display("FAIL two_buttons_summary: pulses=%0d B=%0d expected 1/4", pulses, last_b);
        end
    endtask

    task automatic test_accept_color();
        int g_pulses = 0, p_pulses = 0;
        logic [2:0] last_b = 3'd0;
        for (int i = 1; i <= 47; i++) begin
            tick((i <= 15) ? P_GREEN : (i <= 20) ? 5'd0 : (i <= 35) ? P_POWER : 5'd0, 1'b0);
            checks++;
            if ({R, B, BUSY} !== {exp_r, exp_b, exp_busy}) begin
                errors++;
                $display("FAIL accept_color cyc %0d: got %b/%0d/%b expected %b/%0d/%b",
                         i, R, B, BUSY, exp_r, exp_b, exp_busy);
            end
            if (R && i <= 20) g_pulses++;
            if (R && i > 20) begin p_pulses++; last_b = B; end
        end
        checks++;
        if (g_pulses != 0 || p_pulses != 1 || last_b !== 3'd1) begin
            errors++;
            $display("FAIL accept_color_summary: green=%0d power=%0d B=%0d expected 0/1/1",
                     g_pulses, p_pulses, last_b);
        end
    endtask

    task automatic test_power_through_reset();
        int held_pulses = 0, re_pulses = 0;
        logic [2:0] last_b = 3'd0;
        do_reset(P_POWER);
        for (int i = 1; i <= 69; i++) begin
            tick((i <= 30) ? P_POWER : (i <= 42) ? 5'd0 : (i <= 57) ? P_POWER : 5'd0, 1'b1);
            checks++;
            if ({R, B, BUSY} !== {exp_r, exp_b, exp_busy}) begin
                errors++;
                $display("FAIL power_reset cyc %0d: got %b/%0d/%b expected %b/%0d/%b",
                         i, R, B, BUSY, exp_r, exp_b, exp_busy);
            end
            if (R && i <= 42) held_pulses++;
            if (R && i > 42) begin re_pulses++; last_b = B; end
        end
        checks++;
        if (held_pulses != 0 || re_pulses != 1 || last_b !== 3'd1) begin
            errors++;
            $display("FAIL power_reset_summary: held=%0d again=%0d B=%0d expected 0/1/1",
                     held_pulses, re_pulses, last_b);
        end
    endtask

    task automatic test_reset_in_emit();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(P_YELLOW, 1'b1);
            checks++;
            if ({R, B, BUSY} !== {exp_r, exp_b, exp_busy}) begin
                errors++;
                $display("FAIL emit_press cyc %0d: got %b/%0d/%b expected %b/%0d/%b",
                         i, R, B, BUSY, exp_r, exp_b, exp_busy);
            end
            if (R) seen = 1;
        end
        checks++;
        if (!seen || B !== 3'd6) begin
            errors++;
            $display("FAIL emit_reach: seen=%0d B=%0d expected 1/6", seen, B);
        end
        btn = '0; RESET = 1'b0;
        #1;
        checks++;
        if ({R, B, BUSY} !== 5'b0_000_1) begin
            errors++;
            $display("FAIL emit_async_reset: R/B/BUSY got %b/%0d/%b expected 0/0/1", R, B, BUSY);
        end
        model_reset();
        @(posedge CLK);
        #1 RESET = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick('0, 1'b1);
            checks++;
            if ({R, B, BUSY} !== {exp_r, exp_b, exp_busy}) begin
                errors++;
                $display("FAIL emit_recover cyc %0d: got %b/%0d/%b expected %b/%0d/%b",
                         i, R, B, BUSY, exp_r, exp_b, exp_busy);
            end
        end
    endtask

    task automatic test_random();
        logic acc = 1'b1;
        logic [4:0] pat;
        int r, dur;
        for (int n = 0; n < 120; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 4)      pat = 5'b00001 << r;
            else if (r == 5) pat = 5'd0;
            else             pat = 5'($urandom_range(0, 31));
            dur = $urandom_range(1, 14);
            if ($urandom_range(0, 3) == 0) acc = ~acc;
            for (int k = 0; k < dur; k++) begin
                tick(pat, acc);
                checks++;
                if ({R, B, BUSY} !== {exp_r, exp_b, exp_busy}) begin
                    errors++;
                    $display("FAIL random seg %0d pat %b acc %b: got %b/%0d/%b expected %b/%0d/%b",
                             n, pat, acc, R, B, BUSY, exp_r, exp_b, exp_busy);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_green();
        test_glitch();
        test_two_buttons();
        test_accept_color();
        test_power_through_reset();
        test_reset_in_emit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
